ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It snapshots a packed hex value, per-digit decimal points and digit enables once per frame, then scans one digit per refresh slot. Each slot opens with an anti-ghosting guard interval. Segment, decimal-point and anode outputs are registered and active-low. The block sits between the adder/multiplier result registers and the board display pins.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..16.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 1: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < REFRESH_DIV.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble k (value[4k+3:4k]) drives digit k, where digit 0 is least significant.
- dp  in  DIGITS  decimal point request per digit, active-high.
- digit_en  in  DIGITS  per-digit enable, active-high; a disabled digit is never lit.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp_n  out  1  decimal point segment, active-low.
- an  out  DIGITS  anode selects, active-low, one-hot-or-none.
- frame_done  out  1  one-cycle pulse marking each snapshot load.

## Operation
- **Refresh counter `cnt`:** width clog2(REFRESH_DIV). Counts 0..REFRESH_DIV-1, then wraps to 0.
- **Digit index `idx`:** width max(1, clog2(DIGITS)). Advances when cnt == REFRESH_DIV-1, wrapping from DIGITS-1 to 0. Scan order is 0, 1, …, DIGITS-1.
- **Snapshot registers (`snap_val`, `snap_dp`, `snap_en`):** load value, dp and digit_en:
  - on the first clock edge after rst_n deasserts (tracked by a `primed` flag); and
  - on every edge where cnt == REFRESH_DIV-1 and idx == DIGITS-1, i.e. at frame wrap.
- Input changes at any other time have no effect on the display until the next snapshot load.
- **Digit k is lit when all of the following hold:**
  - idx == k;
  - cnt ≥ GUARD;
  - primed == 1;
  - snap_en[k] == 1;
  - digit k is not blanked (see Configuration).
- **Outputs when digit k is lit:**
  - an = ~(1 << k).
  - seg = hex code of snap_val nibble k.
  - dp_n = ~snap_dp[k].
- **Outputs when no digit is lit:** an = all ones, seg = 7'b1111111, dp_n = 1.
- **Hex codes (abcdefg, active-low):**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000

## Timing
- **Reset values (async, immediate):**
  - cnt=0, idx=0, primed=0.
  - All snapshot registers = 0.
  - an = all ones, seg = 7'b1111111, dp_n = 1, frame_done = 0.
- **Output latency:** seg, dp_n and an are registered. Each output reflects cnt, idx and the snapshot as they were one cycle earlier.
  - First lit digit after reset release: cycle GUARD+2 after the first edge, or cycle 2 when GUARD = 0.
- **frame_done:** registered. High for exactly one cycle, in the cycle after each snapshot load, including the initial load.
- **Frame period:** DIGITS × REFRESH_DIV cycles.
- **Reset mid-frame:** all state returns to reset values immediately. No partial digit is driven after rst_n falls.
- **DIGITS = 1:** idx stays 0, and every slot wrap is a frame wrap.
- **Simultaneous input change and snapshot edge:** the value sampled at that edge is the one displayed.

## Configuration
- **SSD_LZB_EN defined:** leading-zero blanking is compiled in.
  - Digit k is blanked when its snapshot nibble and every higher-index snapshot nibble are 0.
  - Digit 0 is never blanked.
  - A digit whose snap_dp bit is set is never blanked, and it stops blanking for all digits below it.
  - Blanked digits keep an deasserted.
- **SSD_LZB_EN undefined:** no blanking logic is present, and every enabled digit is lit in its slot.

## Test plan
- **Reset:** hold rst_n=0 with value=16'hFFFF and all inputs high → an=4'hF, seg=7'h7F, dp_n=1, frame_done=0. Drop rst_n mid-scan → outputs return to these values without waiting for a clock edge.
- **Basic scan** (DIGITS=4, REFRESH_DIV=4, GUARD=1, value=16'h12A0, dp=0, digit_en=4'hF) → frame_done pulses once. Then, per slot, one off cycle followed by three cycles each of:
  - an=1110 with seg=0000001;
  - an=1101 with seg=0001000;
  - an=1011 with seg=0010010;
  - an=0111 with seg=1001111.
  - frame_done repeats every 16 cycles.
- **Decimal point and enables:** dp=4'b0100, digit_en=4'b1011 → digit 2 is never lit, so its dp_n stays 1. Digits 0, 1 and 3 show dp_n=1.
- **Snapshot stability:** change value from 16'h1111 to 16'h2222 during digit-1 slot → digits 2 and 3 still show 1 (1001111) for the rest of that frame. The next frame shows 2 (0010010) on all digits.
- **Leading-zero blanking (SSD_LZB_EN):**
  - value=16'h0030 → digits 3 and 2 have an=1 throughout; digit 1 shows 0000110; digit 0 shows 0000001.
  - value=0 → only digit 0 is lit.
  - dp[2]=1 with value=16'h0030 → digit 2 is lit as 0000001 with dp_n=0.
- **Guard = 0 and DIGITS=1** (REFRESH_DIV=2, value=4'h8) → an=0 continuously from cycle 2 with seg=0000000. frame_done pulses every 2 cycles.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode 7-seg driver with per-frame snapshot and guard interval.
// Latency: outputs registered, one cycle behind scan state; no backpressure (free-running scan).
// Optional leading-zero blanking when SSD_LZB_EN is defined.
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                primed;
  logic [4*DIGITS-1:0] snap_val;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_en;

  logic              load;
  logic              past_guard;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] cur_onehot;
  logic [3:0]        cur_nib;
  logic              cur_en;
  logic              cur_dp;
  logic              cur_blank;
  logic              lit;

  // First edge after reset primes the snapshot; afterwards only the frame wrap reloads it.
  assign load = !primed || (cnt == CNT_MAX && idx == IDX_MAX);

  generate
    if (GUARD == 0) begin : g_noguard
      assign past_guard = 1'b1;
    end else begin : g_guard
      assign past_guard = (cnt >= CW'(GUARD));
    end
  endgenerate

`ifdef SSD_LZB_EN
  logic zero_run;
  // Walk down from the top digit; any nonzero nibble or set dp ends the blanked run.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (snap_val[4*k +: 4] == 4'h0) && !snap_dp[k];
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_onehot = '0;
    cur_nib    = 4'h0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_onehot[k] = 1'b1;
        cur_nib       = snap_val[4*k +: 4];
        cur_en        = snap_en[k];
        cur_dp        = snap_dp[k];
        cur_blank     = blank[k];
      end
    end
    lit = primed && past_guard && cur_en && !cur_blank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      primed     <= 1'b0;
      snap_val   <= '0;
      snap_dp    <= '0;
      snap_en    <= '0;
      an         <= '1;
      seg        <= 7'b1111111;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      primed     <= 1'b1;
      frame_done <= load;
      if (load) begin
        snap_val <= value;
        snap_dp  <= dp;
        snap_en  <= digit_en;
      end
      // Scan holds at slot 0 until the snapshot is primed.
      if (primed) begin
        if (cnt == CNT_MAX) begin
          cnt <= '0;
          idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      an   <= lit ? ~cur_onehot : '1;
      seg  <= lit ? hex7(cur_nib) : 7'b1111111;
      dp_n <= lit ? ~cur_dp : 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: vector table, hand sequences, and a randomized run against a frame/slot model.
module tb_ssd_scan_driver;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int F  = D * RD;
  localparam int NRAND = 320;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp, digit_en;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  logic [3:0]  value1;
  logic        dp1, en1;
  logic [6:0]  seg1;
  logic        dp_n1;
  logic        an1;
  logic        fd1;

  ssd_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
    .seg(seg), .dp_n(dp_n), .an(an), .frame_done(frame_done));

  ssd_scan_driver #(.DIGITS(1), .REFRESH_DIV(2), .GUARD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value1), .dp(dp1), .digit_en(en1),
    .seg(seg1), .dp_n(dp_n1), .an(an1), .frame_done(fd1));

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [6:0] hex_tab [16];

  logic [15:0] hv [NRAND+2];
  logic [3:0]  hd [NRAND+2];
  logic [3:0]  he [NRAND+2];

  typedef struct packed {
    logic [15:0]      value;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic [3:0][3:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dpn;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic to(input int t);
    while (n < t) step();
  endtask

  // Reset asserted, inputs loaded, released right after an edge so the next edge is edge 1.
  task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    rst_n = 1'b0;
    value = v; dp = d; digit_en = e;
    step();
    rst_n = 1'b1;
    n = 0;
  endtask

  // Expected outputs after edge nn of the 4-digit instance, from frame/slot arithmetic.
  task automatic model(input int nn, output logic [3:0] e_an, output logic [6:0] e_seg,
                       output logic e_dpn, output logic e_fd);
    int p, k, c, ld;
    logic [15:0] sv;
    logic blanked;
    e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
    e_fd = ((nn - 1) % F == 0);
    if (nn >= 2) begin
      p  = nn - 2;
      k  = (p / RD) % D;
      c  = p % RD;
      ld = 1 + F * (p / F);
      sv = hv[ld];
      blanked = 1'b0;
`ifdef SSD_LZB_EN
      if (k > 0) begin
        blanked = 1'b1;
        for (int j = k; j < D; j++)
          if (sv[4*j +: 4] != 4'h0 || hd[ld][j]) blanked = 1'b0;
      end
`endif
      if (c >= G && he[ld][k] && !blanked) begin
        e_an  = ~(4'b0001 << k);
        e_seg = hex_tab[sv[4*k +: 4]];
        e_dpn = ~hd[ld][k];
      end
    end
  endtask

  initial begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dpn, e_fd;

    hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    vecs[0] = '{16'h12A0, 4'h0, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1001111, 7'b0010010, 7'b0001000, 7'b0000001}, 4'b1111};
    vecs[1] = '{16'h3456, 4'b0100, 4'b1011, {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                {7'b0000110, 7'b1111111, 7'b0100100, 7'b0100000}, 4'b1111};
    vecs[2] = '{16'hBCDE, 4'b1001, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b0110};
    vecs[3] = '{16'hF789, 4'b0010, 4'b0101, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111111, 7'b0001111, 7'b1111111, 7'b0000100}, 4'b1111};

    value1 = 4'h8; dp1 = 1'b0; en1 = 1'b1;

    // Reset with all inputs high
    rst_n = 1'b0; value = 16'hFFFF; dp = 4'hF; digit_en = 4'hF;
    #12;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dpn", 32'(dp_n), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_an1", 32'(an1), 32'h1);

    // Vector table: one frame per vector, guard cycle and mid-slot sample per digit
    for (int v = 0; v < 4; v++) begin
      restart(vecs[v].value, vecs[v].dp, vecs[v].en);
      to(1);
      chk("fd_first", 32'(frame_done), 32'h1);
      for (int k = 0; k < D; k++) begin
        to(4*k + 2);
        chk("guard_an", 32'(an), 32'hF);
        to(4*k + 4);
        chk("vec_an", 32'(an), 32'(vecs[v].an[k]));
        chk("vec_seg", 32'(seg), 32'(vecs[v].seg[k]));
        chk("vec_dpn", 32'(dp_n), 32'(vecs[v].dpn[k]));
      end
      to(17);
      chk("fd_frame", 32'(frame_done), 32'h1);
      to(18);
      chk("fd_low", 32'(frame_done), 32'h0);
    end

    // Reset dropped while a digit is lit clears outputs without a clock edge
    restart(16'h12A0, 4'h1, 4'hF);
    to(8);
    chk("mid_lit_an", 32'(an), 32'hD);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dpn", 32'(dp_n), 32'h1);
    chk("mid_rst_an1", 32'(an1), 32'h1);

    // Snapshot stability: input change mid-frame shows only from the next frame
    restart(16'h1111, 4'h0, 4'hF);
    to(7);
    value = 16'h2222;
    to(12);
    chk("stab_d2", 32'(seg), 32'(7'b1001111));
    to(16);
    chk("stab_d3", 32'(seg), 32'(7'b1001111));
    to(20);
    chk("stab_next", 32'(seg), 32'(7'b0010010));

`ifdef SSD_LZB_EN
    restart(16'h0030, 4'h0, 4'hF);
    to(4);  chk("lzb_d0", 32'(seg), 32'(7'b0000001));
    to(8);  chk("lzb_d1", 32'(seg), 32'(7'b0000110));
    to(12); chk("lzb_d2", 32'(an), 32'hF);
    to(16); chk("lzb_d3", 32'(an), 32'hF);
    restart(16'h0030, 4'b0100, 4'hF);
    to(12);
    chk("lzb_dp_an", 32'(an), 32'hB);
    chk("lzb_dp_seg", 32'(seg), 32'(7'b0000001));
    chk("lzb_dp_dpn", 32'(dp_n), 32'h0);
`endif

    // Randomized run; inputs change every cycle, only snapshots matter
    restart(16'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < NRAND; i++) begin
      hv[n+1] = value; hd[n+1] = dp; he[n+1] = digit_en;
      step();
      model(n, e_an, e_seg, e_dpn, e_fd);
      chk("rnd_an", 32'(an), 32'(e_an));
      chk("rnd_seg", 32'(seg), 32'(e_seg));
      chk("rnd_dpn", 32'(dp_n), 32'(e_dpn));
      chk("rnd_fd", 32'(frame_done), 32'(e_fd));
      chk("d1_an", 32'(an1), (n >= 2) ? 32'h0 : 32'h1);
      if (n >= 2) chk("d1_seg", 32'(seg1), 32'(7'b0000000));
      chk("d1_fd", 32'(fd1), 32'((n % 2) == 1));
      value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      digit_en = 4'($urandom) | 4'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
